// File: rtl/t_ff_checker.sv
// Self-checking monitor for a posedge T flip-flop: predicts Q, counts toggles/mismatches.
// Optional T_FF_CHK_QBAR_EN also verifies Qbar == ~Q in CHECK.
module t_ff_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             T,
   input  logic             Q,
   input  logic             Qbar,
   output logic             synced,
   output logic             err,
   output logic             mismatch,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      UNSYNC,
      SYNC,
      CHECK
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   state_t state_nxt;
   logic   t_s;
   logic   q_s;
   logic   chk;
   logic   pred_bad;
   logic   qbar_bad;
   logic   viol;
   logic   tog;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UNSYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         UNSYNC:  state_nxt = SYNC;
         SYNC:    state_nxt = CHECK;
         CHECK:   state_nxt = CHECK;
         default: state_nxt = UNSYNC;
      endcase
      if (!en) begin
         state_nxt = UNSYNC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_s <= 1'b0;
         q_s <= 1'b0;
      end else begin
         t_s <= T;
         q_s <= Q;
      end
   end

   // Prediction uses the observed Q, so one bad edge never propagates.
   assign chk      = en && (state == CHECK);
   assign pred_bad = Q != (q_s ^ t_s);
   assign tog      = chk && (Q != q_s);

`ifdef T_FF_CHK_QBAR_EN
   assign qbar_bad = Qbar == Q;
`else
   logic unused_qbar;
   assign unused_qbar = Qbar;
   assign qbar_bad    = 1'b0;
`endif

   assign viol   = chk && (pred_bad || qbar_bad);
   assign synced = state == CHECK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err        <= 1'b0;
         mismatch   <= 1'b0;
         toggle_cnt <= '0;
         err_cnt    <= '0;
      end else if (clr) begin
         err        <= 1'b0;
         mismatch   <= 1'b0;
         toggle_cnt <= '0;
         err_cnt    <= '0;
      end else begin
         mismatch <= viol;
         if (viol) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
         if (tog && (toggle_cnt != CNT_MAX)) begin
            toggle_cnt <= toggle_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_t_ff_checker.sv
// Bench for t_ff_checker: directed table, hand sequences, random run vs. reference model.
// Two instances (CNT_W=8 and CNT_W=3) share stimulus to cover saturation.
module tb_t_ff_checker;

`ifdef T_FF_CHK_QBAR_EN
   localparam bit QB = 1'b1;
`else
   localparam bit QB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, en, clr, T, Q, Qbar;
   logic s8, e8, m8, s3, e3, m3;
   logic [7:0] tc8, ec8;
   logic [2:0] tc3, ec3;

   t_ff_checker #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .T(T), .Q(Q), .Qbar(Qbar),
      .synced(s8), .err(e8), .mismatch(m8),
      .toggle_cnt(tc8), .err_cnt(ec8)
   );

   t_ff_checker #(.CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .T(T), .Q(Q), .Qbar(Qbar),
      .synced(s3), .err(e3), .mismatch(m3),
      .toggle_cnt(tc3), .err_cnt(ec3)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // flip-flop under test and stimulus knobs
   bit ffq = 0;
   bit stuck = 0;
   bit badqb = 0;
   int force_q = -1;

   // reference model: counts since last clear, enabled-edge run length
   int run = 0;
   bit pq = 0, pt = 0;
   int tcnt = 0, ecnt = 0;
   bit merr = 0, mmis = 0;

   function automatic int sat(int v, int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      run = 0; pq = 0; pt = 0;
      tcnt = 0; ecnt = 0; merr = 0; mmis = 0;
   endtask

   task automatic model_edge();
      bit checking, viol, tg;
      if (!rst_n) begin
         model_reset();
         return;
      end
      checking = en && (run >= 2);
      viol = checking && ((Q != (pq ^ pt)) || (QB && (Qbar == Q)));
      tg = checking && (Q != pq);
      if (clr) begin
         tcnt = 0; ecnt = 0; merr = 0; mmis = 0;
      end else begin
         mmis = viol;
         if (viol) begin
            merr = 1; ecnt++;
         end
         if (tg) tcnt++;
      end
      pq = Q; pt = T;
      run = en ? ((run < 2) ? run + 1 : 2) : 0;
   endtask

   task automatic check_all(string tag);
      chk({tag, ".synced8"}, int'(s8), int'(run >= 2));
      chk({tag, ".err8"}, int'(e8), int'(merr));
      chk({tag, ".mis8"}, int'(m8), int'(mmis));
      chk({tag, ".tog8"}, int'(tc8), sat(tcnt, 8));
      chk({tag, ".ecnt8"}, int'(ec8), sat(ecnt, 8));
      chk({tag, ".synced3"}, int'(s3), int'(run >= 2));
      chk({tag, ".err3"}, int'(e3), int'(merr));
      chk({tag, ".mis3"}, int'(m3), int'(mmis));
      chk({tag, ".tog3"}, int'(tc3), sat(tcnt, 3));
      chk({tag, ".ecnt3"}, int'(ec3), sat(ecnt, 3));
   endtask

   // one clock: present Q/Qbar, predict, clock, advance the FF, compare
   task automatic tick(string tag);
      Q = (force_q >= 0) ? force_q[0] : ffq;
      Qbar = badqb ? Q : ~Q;
      model_edge();
      @(posedge clk);
      if (!stuck) ffq = ffq ^ T;
      #1;
      check_all(tag);
   endtask

   typedef struct {
      bit t, en, clr, stuck, bq;
      bit s, m, e;
      int ec;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[2]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{1, 1, 0, 1, 0, 1, 0, 0, 0};
      tbl[4]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
      tbl[5]  = '{1, 1, 0, 0, 0, 1, 0, 1, 1};
      tbl[6]  = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
      tbl[7]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
      tbl[8]  = '{1, 1, 0, 0, 1, 1, QB, QB, int'(QB)};
      tbl[9]  = '{1, 1, 1, 1, 0, 1, 0, 0, 0};
      tbl[10] = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
      tbl[11] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[15] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};

      rst_n = 0; en = 1; clr = 0; T = 1; Q = 0; Qbar = 1;
      model_reset();
      @(posedge clk); #1;

      // reset held with T=1 and Q toggling
      for (int i = 0; i < 3; i++) tick("rst");
      chk("rst.synced", int'(s8), 0);

      ffq = 0;
      rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         T = tbl[i].t; en = tbl[i].en; clr = tbl[i].clr;
         stuck = tbl[i].stuck; badqb = tbl[i].bq;
         tick("tbl");
         chk($sformatf("vec%0d.synced", i), int'(s8), int'(tbl[i].s));
         chk($sformatf("vec%0d.mis", i), int'(m8), int'(tbl[i].m));
         chk($sformatf("vec%0d.err", i), int'(e8), int'(tbl[i].e));
         chk($sformatf("vec%0d.ecnt", i), int'(ec8), tbl[i].ec);
      end
      stuck = 0; badqb = 0; clr = 0; en = 1;

      // correct FF, T alternating every 2 clocks
      clr = 1; T = 0; tick("clr"); clr = 0;
      for (int i = 0; i < 40; i++) begin
         T = ((i / 2) % 2) == 1;
         tick("alt");
      end
      chk("alt.err", int'(e8), 0);
      chk("alt.ecnt", int'(ec8), 0);

      // pause with arbitrary Q, then resync
      for (int i = 0; i < 5; i++) begin
         en = 0; T = 1'($urandom); force_q = int'($urandom_range(0, 1));
         tick("pause");
      end
      force_q = -1; en = 1;
      for (int i = 0; i < 6; i++) begin
         T = 1'($urandom);
         tick("resync");
      end
      chk("resync.mis", int'(m8), 0);

      // saturation: toggles, then a mismatch on every edge
      clr = 1; tick("clr"); clr = 0;
      T = 1;
      for (int i = 0; i < 20; i++) tick("sat_tog");
      chk("sat.tog3", int'(tc3), 7);
      stuck = 1;
      for (int i = 0; i < 10; i++) tick("sat_err");
      chk("sat.ecnt3", int'(ec3), 7);
      clr = 1; tick("sat_clr"); clr = 0;
      chk("satclr.ecnt3", int'(ec3), 0);
      stuck = 0;
      for (int i = 0; i < 300; i++) tick("sat8");
      chk("sat.tog8", int'(tc8), 255);

      // random run
      for (int i = 0; i < 400; i++) begin
         T = 1'($urandom);
         en = ($urandom_range(0, 15) != 0);
         clr = ($urandom_range(0, 31) == 0);
         stuck = ($urandom_range(0, 19) == 0);
         badqb = ($urandom_range(0, 29) == 0);
         force_q = en ? -1 : int'($urandom_range(0, 1));
         tick("rand");
      end
      stuck = 0; badqb = 0; clr = 0; en = 1; force_q = -1;

      // asynchronous reset between edges
      #2 rst_n = 0;
      #1 model_reset();
      check_all("async_rst");
      #1 rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         T = 1'($urandom);
         tick("post_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/t_ff_checker.md
# t_ff_checker

Self-checking monitor for the posedge T flip-flop: the receiving end of the T/Q interface that the flip-flop's stimulus side drives. Every rising clock edge it samples the T input and the Q/Qbar outputs of the flip-flop under test, predicts Q from a one-bit reference model, and reports observed toggles, mismatches and a sticky error flag. It sits beside the flip-flop in test benches and on-chip self-test wrappers, and is fully synthesizable.

## Interface
Parameters:
- CNT_W, 8, width of both event counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all sampling is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enables checking; low pauses and forces resynchronization.
- clr  in  1  synchronous clear of the counters and the sticky error; FSM state unaffected.
- T  in  1  toggle input applied to the flip-flop under test.
- Q  in  1  flip-flop output.
- Qbar  in  1  flip-flop complementary output.
- synced  out  1  high while in CHECK state.
- err  out  1  sticky mismatch flag.
- mismatch  out  1  one-cycle pulse on each detected mismatch.
- toggle_cnt  out  CNT_W  count of observed Q changes while synced.
- err_cnt  out  CNT_W  count of mismatches.

## Operation
- Sampling: at each rising edge n, register T_s(n) = T and Q_s(n) = Q (pre-edge values). The model is Q_s(n) == Q_s(n-1) XOR T_s(n-1).
- FSM states:
  - UNSYNC: reset state. On an edge with en=1, capture Q_s/T_s and go to SYNC.
  - SYNC: on the next edge with en=1, capture again and go to CHECK. The first comparison happens in CHECK.
  - CHECK: compare on every enabled edge.
- Any edge with en=0, in any state: go to UNSYNC. Counters hold; no checks are made.
- Mismatch (CHECK only): pulse mismatch for 1 cycle, set err, and increment err_cnt (saturating). The model then resynchronizes to the observed Q, so a single stuck toggle is counted once and is not propagated.
- Toggle count (CHECK only): increment toggle_cnt (saturating) when Q_s(n) != Q_s(n-1), whether or not a mismatch occurred.
- clr=1: toggle_cnt, err_cnt, err and mismatch all go to 0 on that edge. clr has priority over a simultaneous increment or error set. The FSM and the sampled history continue.
- Width rule: the counters are unsigned CNT_W bits. At all-ones they stay at all-ones and never wrap.

## Timing
- Reset values (asynchronous, while rst_n=0): FSM=UNSYNC, synced=0, err=0, mismatch=0, toggle_cnt=0, err_cnt=0, sample registers=0.
- synced rises 2 enabled edges after reset release or after en returns high.
- mismatch/err latency: registered outputs, high from the edge at which the faulty Q is sampled.
- en deasserted for one cycle: synced falls at that edge, and the checker needs 2 further enabled edges to resume checking.
- Reset asserted mid-operation: all outputs clear immediately, without waiting for a clock edge.

## Configuration
- T_FF_CHK_QBAR_EN defined:
  - In CHECK, each edge also verifies Qbar == ~Q.
  - A violation counts as a mismatch: pulse, err, err_cnt+1. It is counted at most once per edge, even if the Q prediction also fails.
- T_FF_CHK_QBAR_EN undefined: the Qbar input is ignored (unused port retained).

## Test plan
- Reset behaviour: hold rst_n=0 for 3 cycles with T=1 and Q toggling -> all outputs 0, synced=0. Release reset -> synced=1 after the 2nd edge.
- Correct operation: connect a correct flip-flop, drive T alternating every 2 clocks for 40 cycles -> err=0, err_cnt=0, toggle_cnt = number of T=1 sampled cycles after sync (20 ±1 at boundary, exact value computed by the bench model).
- Stuck output: force Q stuck at 0 for one cycle while T=1 -> mismatch pulses once, err=1, err_cnt=1. Release the force -> no further mismatches and err stays 1. Then clr -> err=0, err_cnt=0.
- Pause and resync: en=0 for 5 cycles while Q is forced to arbitrary values -> no change in counters, synced=0. en=1 -> synced after 2 edges, no false mismatch.
- Saturation: CNT_W=3, T=1 constant for 20 cycles -> toggle_cnt stops at 7. With a mismatch every cycle -> err_cnt stops at 7. clr asserted on the same edge as a mismatch -> counters read 0.
- With T_FF_CHK_QBAR_EN defined: drive Qbar = Q for one cycle while Q is correct -> err_cnt=1. Repeat with the macro undefined -> err_cnt=0.
